time_counter: RTL and testbench
===============================

# time_counter

Current-time keeper for the alarm clock. It consumes the one_minute and one_second pulse streams from the time-generation unit and holds the displayed time as four BCD digits in HH:MM, 24-hour format. It accepts a new current time from the alarm controller and produces a colon-blink indicator and an end-of-day wrap pulse. It sits between the time generator and the display driver and alarm comparator.

## Interface
- Parameters: none.
- clock  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- one_minute  input  1  single-cycle pulse; advances time by one minute.
- one_second  input  1  single-cycle pulse; toggles the colon.
- load_new_c  input  1  single-cycle request to load new_current_time_* into the current time.
- new_current_time_ms_hr  input  4  BCD tens-of-hours to load.
- new_current_time_ls_hr  input  4  BCD units-of-hours to load.
- new_current_time_ms_min  input  4  BCD tens-of-minutes to load.
- new_current_time_ls_min  input  4  BCD units-of-minutes to load.
- current_time_ms_hr  output  4  tens of hours, 0–2.
- current_time_ls_hr  output  4  units of hours, 0–9 (0–3 when ms_hr = 2).
- current_time_ms_min  output  4  tens of minutes, 0–5.
- current_time_ls_min  output  4  units of minutes, 0–9.
- colon  output  1  blink indicator; toggles once per second.
- day_wrap  output  1  single-cycle pulse when the time wraps 23:59 → 00:00.
- load_error  output  1  single-cycle pulse when a load request is rejected.

## Operation
- All outputs are registered.
- Reset (reset_n = 0, asynchronous): all four time digits = 0, colon = 0, day_wrap = 0, load_error = 0.
- Load validation: the load is valid iff all of the following hold:
  - ms_hr ≤ 2
  - ls_hr ≤ 9
  - if ms_hr = 2, then ls_hr ≤ 3
  - ms_min ≤ 5
  - ls_min ≤ 9
- Valid load: all four digits take the new values, colon is cleared to 0, and no increment happens that cycle.
- Invalid load: the digits hold their values, load_error pulses for 1 cycle, and a coincident one_minute is still applied.
- Priority when several inputs are high in the same cycle: valid load_new_c, then one_minute. one_second is independent of the time digits, but a valid load overrides the colon toggle (colon = 0).
- Minute increment on one_minute = 1:
  - ls_min 0–8: ls_min + 1.
  - ls_min = 9: ls_min → 0 and carry into ms_min.
  - ms_min with carry: +1, or 5 → 0 with carry into hours.
  - Hours with carry: 23 → 00 (the day wrap). Otherwise ls_hr 9 → 0 with ms_hr + 1, else ls_hr + 1.
- day_wrap = 1 for exactly the cycle after an increment from 23:59. It is 0 otherwise, including when a load sets 00:00.
- colon toggles on every one_second pulse that is not blocked by a valid load.
- Time digits never hold an invalid BCD value, since only validated loads and the increment path write them.

## Timing
- Latency: input sampled at edge N, so digits, colon and flags are visible after edge N, i.e. 1 cycle.
- one_minute held high for k cycles produces k increments. The block relies on single-cycle pulses and does not detect edges.
- Reset deasserted mid-operation: the state restarts from 00:00 with colon 0. No pending pulse survives reset.
- reset_n asserted while one_minute is high: the reset wins and the digits are 0 immediately, without waiting for a clock edge.
- load_error and day_wrap never assert together.

## Test plan
- Reset, then release and wait 5 cycles with no pulses → digits 00:00, colon 0, day_wrap 0, load_error 0.
- Load 12:58 then two one_minute pulses 3 cycles apart → 12:59, then 13:00, each visible 1 cycle after its pulse.
- Load 23:59, then one_minute → 00:00 and day_wrap high for exactly 1 cycle. A following pulse gives 00:01 with day_wrap 0.
- load_new_c with 19:45 and one_minute in the same cycle → 19:45 (no increment), colon 0.
- Load 24:00 or 09:60 from a current time of 07:30, same cycle as one_minute → load_error pulses for 1 cycle, time becomes 07:31.
- Four one_second pulses from colon 0 → colon sequence 1, 0, 1, 0. A valid load coinciding with the 3rd pulse → colon 0 at that point.

Source files
------------

// File: rtl/time_counter.sv
// Current-time keeper: HH:MM in BCD, 24-hour, with validated loads,
// colon blink and end-of-day wrap pulse.
module time_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       one_minute,
  input  logic       one_second,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       colon,
  output logic       day_wrap,
  output logic       load_error
);

  localparam int unsigned DW = 4;

  logic [DW-1:0] r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
  logic          r_colon, r_day_wrap, r_load_error;

  logic          w_fmt_ok, w_load_ok, w_load_bad;
  logic          w_min_carry, w_hr_carry, w_wrap;
  logic [DW-1:0] w_inc_ms_hr, w_inc_ls_hr, w_inc_ms_min, w_inc_ls_min;

  // Load validation: legal 24-hour BCD time only
  always_comb begin
    w_fmt_ok = (new_current_time_ms_hr  <= DW'(2)) &&
               (new_current_time_ls_hr  <= DW'(9)) &&
               !((new_current_time_ms_hr == DW'(2)) && (new_current_time_ls_hr > DW'(3))) &&
               (new_current_time_ms_min <= DW'(5)) &&
               (new_current_time_ls_min <= DW'(9));
    w_load_ok = load_new_c && w_fmt_ok;
    // A wrap coinciding with a rejected load reports only the wrap
    w_load_bad = load_new_c && !w_fmt_ok && !(one_minute && w_wrap);
  end

  // One-minute increment with BCD carries and 23:59 -> 00:00 wrap
  always_comb begin
    w_min_carry  = (r_ls_min == DW'(9));
    w_hr_carry   = w_min_carry && (r_ms_min == DW'(5));
    w_wrap       = w_hr_carry && (r_ms_hr == DW'(2)) && (r_ls_hr == DW'(3));

    w_inc_ls_min = w_min_carry ? '0 : r_ls_min + DW'(1);
    w_inc_ms_min = r_ms_min;
    w_inc_ls_hr  = r_ls_hr;
    w_inc_ms_hr  = r_ms_hr;

    if (w_min_carry) begin
      w_inc_ms_min = (r_ms_min == DW'(5)) ? '0 : r_ms_min + DW'(1);
    end
    if (w_hr_carry) begin
      if (w_wrap) begin
        w_inc_ms_hr = '0;
        w_inc_ls_hr = '0;
      end else if (r_ls_hr == DW'(9)) begin
        w_inc_ls_hr = '0;
        w_inc_ms_hr = r_ms_hr + DW'(1);
      end else begin
        w_inc_ls_hr = r_ls_hr + DW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ms_hr      <= '0;
      r_ls_hr      <= '0;
      r_ms_min     <= '0;
      r_ls_min     <= '0;
      r_colon      <= 1'b0;
      r_day_wrap   <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_day_wrap   <= 1'b0;
      r_load_error <= w_load_bad;
      if (w_load_ok) begin
        r_ms_hr  <= new_current_time_ms_hr;
        r_ls_hr  <= new_current_time_ls_hr;
        r_ms_min <= new_current_time_ms_min;
        r_ls_min <= new_current_time_ls_min;
        r_colon  <= 1'b0;
      end else begin
        if (one_minute) begin
          r_ms_hr    <= w_inc_ms_hr;
          r_ls_hr    <= w_inc_ls_hr;
          r_ms_min   <= w_inc_ms_min;
          r_ls_min   <= w_inc_ls_min;
          r_day_wrap <= w_wrap;
        end
        if (one_second) begin
          r_colon <= ~r_colon;
        end
      end
    end
  end

  assign current_time_ms_hr  = r_ms_hr;
  assign current_time_ls_hr  = r_ls_hr;
  assign current_time_ms_min = r_ms_min;
  assign current_time_ls_min = r_ls_min;
  assign colon               = r_colon;
  assign day_wrap            = r_day_wrap;
  assign load_error          = r_load_error;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: one table row per clock cycle, plus
// hand-written sequences for asynchronous reset behaviour.
module tb_time_counter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       one_minute = 1'b0;
  logic       one_second = 1'b0;
  logic       load_new_c = 1'b0;
  logic [3:0] n_mh = '0, n_lh = '0, n_mm = '0, n_lm = '0;
  logic [3:0] c_mh, c_lh, c_mm, c_lm;
  logic       colon, day_wrap, load_error;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  time_counter dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .one_minute              (one_minute),
    .one_second              (one_second),
    .load_new_c              (load_new_c),
    .new_current_time_ms_hr  (n_mh),
    .new_current_time_ls_hr  (n_lh),
    .new_current_time_ms_min (n_mm),
    .new_current_time_ls_min (n_lm),
    .current_time_ms_hr      (c_mh),
    .current_time_ls_hr      (c_lh),
    .current_time_ms_min     (c_mm),
    .current_time_ls_min     (c_lm),
    .colon                   (colon),
    .day_wrap                (day_wrap),
    .load_error              (load_error)
  );

  typedef struct {
    string       name;
    logic        om;
    logic        os;
    logic        ld;
    logic [15:0] nt;
    logic [15:0] et;
    logic        ec;
    logic        edw;
    logic        ele;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic om, input logic os,
                     input logic ld, input logic [15:0] nt, input logic [15:0] et,
                     input logic ec, input logic edw, input logic ele);
    vec_t v;
    v.name = name; v.om = om; v.os = os; v.ld = ld; v.nt = nt;
    v.et = et; v.ec = ec; v.edw = edw; v.ele = ele;
    vecs.push_back(v);
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic check_all(input string name, input logic [15:0] et, input logic ec,
                           input logic edw, input logic ele);
    chk16({name, " time"}, {c_mh, c_lh, c_mm, c_lm}, et);
    chk1({name, " colon"}, colon, ec);
    chk1({name, " day_wrap"}, day_wrap, edw);
    chk1({name, " load_error"}, load_error, ele);
  endtask

  task automatic drive(input logic om, input logic os, input logic ld, input logic [15:0] nt);
    one_minute = om;
    one_second = os;
    load_new_c = ld;
    {n_mh, n_lh, n_mm, n_lm} = nt;
  endtask

  initial begin
    // name, om, os, ld, new time, exp time, colon, day_wrap, load_error
    for (int i = 0; i < 5; i++) add("idle", 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add("load 12:58",       0, 0, 1, 16'h1258, 16'h1258, 0, 0, 0);
    add("min -> 12:59",     1, 0, 0, 16'h0000, 16'h1259, 0, 0, 0);
    add("gap1",             0, 0, 0, 16'h0000, 16'h1259, 0, 0, 0);
    add("gap2",             0, 0, 0, 16'h0000, 16'h1259, 0, 0, 0);
    add("min -> 13:00",     1, 0, 0, 16'h0000, 16'h1300, 0, 0, 0);
    add("load 23:59",       0, 0, 1, 16'h2359, 16'h2359, 0, 0, 0);
    add("wrap -> 00:00",    1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    add("wrap pulse ends",  0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add("min -> 00:01",     1, 0, 0, 16'h0000, 16'h0001, 0, 0, 0);
    add("load 19:45 + min", 1, 0, 1, 16'h1945, 16'h1945, 0, 0, 0);
    add("load 07:30",       0, 0, 1, 16'h0730, 16'h0730, 0, 0, 0);
    add("bad 24:00 + min",  1, 0, 1, 16'h2400, 16'h0731, 0, 0, 1);
    add("err pulse ends",   0, 0, 0, 16'h0000, 16'h0731, 0, 0, 0);
    add("bad 09:60 + min",  1, 0, 1, 16'h0960, 16'h0732, 0, 0, 1);
    add("bad 30:00",        0, 0, 1, 16'h3000, 16'h0732, 0, 0, 1);
    add("bad 0a:00",        0, 0, 1, 16'h0a00, 16'h0732, 0, 0, 1);
    add("bad 12:0a",        0, 0, 1, 16'h120a, 16'h0732, 0, 0, 1);
    add("load 00:00 no dw", 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    add("sec 1",            0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add("sec 2",            0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add("sec 3",            0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add("sec 4",            0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add("sec 5",            0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0);
    add("sec 6",            0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add("sec 7 + load",     0, 1, 1, 16'h1000, 16'h1000, 0, 0, 0);
    add("sec 8",            0, 1, 0, 16'h0000, 16'h1000, 1, 0, 0);
    add("sec + bad load",   0, 1, 1, 16'h2500, 16'h1000, 0, 0, 1);
    add("load 09:59",       0, 0, 1, 16'h0959, 16'h0959, 0, 0, 0);
    add("min -> 10:00",     1, 0, 0, 16'h0000, 16'h1000, 0, 0, 0);
    add("load 19:59",       0, 0, 1, 16'h1959, 16'h1959, 0, 0, 0);
    add("min -> 20:00",     1, 0, 0, 16'h0000, 16'h2000, 0, 0, 0);
    add("load 00:58",       0, 0, 1, 16'h0058, 16'h0058, 0, 0, 0);
    add("held min 1",       1, 0, 0, 16'h0000, 16'h0059, 0, 0, 0);
    add("held min 2",       1, 0, 0, 16'h0000, 16'h0100, 0, 0, 0);
    add("held min 3",       1, 0, 0, 16'h0000, 16'h0101, 0, 0, 0);
    add("load 23:49",       0, 0, 1, 16'h2349, 16'h2349, 0, 0, 0);
    add("min -> 23:50",     1, 1, 0, 16'h0000, 16'h2350, 1, 0, 0);
    add("idle end",         0, 0, 0, 16'h0000, 16'h2350, 1, 0, 0);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_all("reset", 16'h0000, 0, 0, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].om, vecs[i].os, vecs[i].ld, vecs[i].nt);
      @(posedge clock);
      #1;
      check_all($sformatf("row%0d %s", i, vecs[i].name),
                vecs[i].et, vecs[i].ec, vecs[i].edw, vecs[i].ele);
    end

    // Async reset while one_minute is high clears digits without an edge
    drive(1, 0, 0, 16'h0000);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async reset", 16'h0000, 0, 0, 0);
    @(posedge clock);
    #1;
    check_all("reset held over edge", 16'h0000, 0, 0, 0);

    // Release mid-cycle: state restarts from 00:00, then counts normally
    drive(0, 0, 0, 16'h0000);
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_all("after release", 16'h0000, 0, 0, 0);
    drive(1, 1, 0, 16'h0000);
    @(posedge clock);
    #1;
    check_all("first min after reset", 16'h0001, 1, 0, 0);
    drive(0, 0, 0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
